// File: rtl/r8051_uart_sfr.sv
// Serial-port SFR block for the r8051: SCON/SBUF decode, 8N1 transmitter and receiver.
// TI/RI are hardware-set flags that software clears by writing SCON.
module r8051_uart_sfr #(
  parameter int CLK_DIV  = 16,
  parameter bit TI_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ram_rd_en_sfr,
  input  logic [7:0] ram_rd_addr,
  input  logic       ram_wr_en_sfr,
  input  logic [7:0] ram_wr_addr,
  input  logic [7:0] ram_wr_byte,
  output logic [7:0] sfr_rd_byte,
  output logic       sfr_rd_hit,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam logic [7:0]  ADDR_SCON = 8'h98;
  localparam logic [7:0]  ADDR_SBUF = 8'h99;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]  scon, scon_next, rx_buf;
  state_t      tx_state, rx_state;
  logic [15:0] tx_baud, rx_baud;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shift, rx_shift;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic        scon_wr, sbuf_wr, ren;
  logic        tx_last, tx_done, tx_ready;
  logic        rx_last, rx_set;

  assign scon_wr  = ram_wr_en_sfr && (ram_wr_addr == ADDR_SCON);
  assign sbuf_wr  = ram_wr_en_sfr && (ram_wr_addr == ADDR_SBUF);
  assign ren      = scon[4];

  // The last clock of STOP counts as idle so a write on that edge chains a new frame.
  assign tx_last  = (tx_baud == BAUD_LAST);
  assign tx_done  = (tx_state == S_STOP) && tx_last;
  assign tx_ready = (tx_state == S_IDLE) || tx_done;

  assign rx_last  = (rx_baud == BAUD_LAST);
  assign rx_set   = ren && (rx_state == S_STOP) && rx_last && rxd_sync && !scon[0];

  // Hardware flag sets are applied after the software write so they win a collision.
  always_comb begin
    scon_next = scon_wr ? ram_wr_byte : scon;
    if (tx_done) scon_next[1] = 1'b1;
    if (rx_set)  scon_next[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scon <= {6'b0, TI_RESET, 1'b0};
    else        scon <= scon_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfr_rd_byte <= 8'h00;
      sfr_rd_hit  <= 1'b0;
    end else begin
      sfr_rd_hit <= 1'b0;
      if (ram_rd_en_sfr && ram_rd_addr == ADDR_SCON) begin
        sfr_rd_byte <= scon;
        sfr_rd_hit  <= 1'b1;
      end else if (ram_rd_en_sfr && ram_rd_addr == ADDR_SBUF) begin
        sfr_rd_byte <= rx_buf;
        sfr_rd_hit  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_baud  <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      uart_txd <= 1'b1;
    end else if (sbuf_wr && tx_ready) begin
      tx_state <= S_START;
      tx_baud  <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= ram_wr_byte;
      uart_txd <= 1'b0;
    end else if (tx_state != S_IDLE) begin
      if (!tx_last) begin
        tx_baud <= tx_baud + 16'd1;
      end else begin
        tx_baud <= 16'd0;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
          S_DATA: begin
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              uart_txd <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // Synchronizer flops reset high so release of reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= S_IDLE;
      rx_baud  <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_buf   <= 8'h00;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      if (!ren) begin
        rx_state <= S_IDLE;
        rx_baud  <= 16'd0;
        rx_bit   <= 3'd0;
      end else begin
        case (rx_state)
          S_IDLE: begin
            if (rxd_prev && !rxd_sync) begin
              rx_state <= S_START;
              rx_baud  <= 16'd0;
            end
          end
          S_START: begin
            if (rx_baud == HALF_LAST) begin
              rx_baud  <= 16'd0;
              rx_bit   <= 3'd0;
              rx_state <= rxd_sync ? S_IDLE : S_DATA;
            end else begin
              rx_baud <= rx_baud + 16'd1;
            end
          end
          S_DATA: begin
            if (rx_last) begin
              rx_baud  <= 16'd0;
              rx_shift <= {rxd_sync, rx_shift[7:1]};
              if (rx_bit == 3'd7) rx_state <= S_STOP;
              else                rx_bit   <= rx_bit + 3'd1;
            end else begin
              rx_baud <= rx_baud + 16'd1;
            end
          end
          default: begin
            if (rx_last) begin
              rx_baud  <= 16'd0;
              rx_state <= S_IDLE;
              if (rx_set) rx_buf <= rx_shift;
            end else begin
              rx_baud <= rx_baud + 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_r8051_uart_sfr.sv
// Directed self-checking bench for r8051_uart_sfr with CLK_DIV=16.
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_r8051_uart_sfr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ram_rd_en_sfr;
  logic [7:0] ram_rd_addr;
  logic       ram_wr_en_sfr;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_wr_byte;
  logic [7:0] sfr_rd_byte;
  logic       sfr_rd_hit;
  logic       uart_txd;
  logic       uart_rxd;

  int vectors = 0;
  int miscompares = 0;

  r8051_uart_sfr #(.CLK_DIV(16), .TI_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_rd_en_sfr(ram_rd_en_sfr), .ram_rd_addr(ram_rd_addr),
    .ram_wr_en_sfr(ram_wr_en_sfr), .ram_wr_addr(ram_wr_addr), .ram_wr_byte(ram_wr_byte),
    .sfr_rd_byte(sfr_rd_byte), .sfr_rd_hit(sfr_rd_hit),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd)
  );

  always #5 clk = ~clk;

  // Each bus task starts and ends just after a falling edge.
  task automatic sfr_wr(input logic [7:0] addr, input logic [7:0] data);
    ram_wr_en_sfr = 1'b1; ram_wr_addr = addr; ram_wr_byte = data;
    @(negedge clk);
    ram_wr_en_sfr = 1'b0;
  endtask

  task automatic sfr_rd(input logic [7:0] addr, output logic [7:0] data, output logic hit);
    ram_rd_en_sfr = 1'b1; ram_rd_addr = addr;
    @(negedge clk);
    ram_rd_en_sfr = 1'b0;
    data = sfr_rd_byte; hit = sfr_rd_hit;
  endtask

  task automatic drive_rx_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = frame[b];
      repeat (16) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] d; logic h;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_txd got=%b exp=1", uart_txd); end
    vectors++; if (sfr_rd_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rd_byte got=%h exp=00", sfr_rd_byte); end
    vectors++; if (sfr_rd_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_hit got=%b exp=0", sfr_rd_hit); end
    rst_n = 1'b1;
    @(negedge clk);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("[TB] FAIL reset_scon got=%h exp=02", d); end
    vectors++; if (h !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_scon_hit got=%b exp=1", h); end
    @(negedge clk);
    vectors++; if (sfr_rd_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_one_cycle got=%b exp=0", sfr_rd_hit); end
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_txd got=%b exp=1", uart_txd); end
  endtask

  task automatic test_addr_decode;
    logic [7:0] d; logic h;
    sfr_wr(8'h98, 8'h10);
    ram_rd_en_sfr = 1'b1; ram_rd_addr = 8'h98;
    ram_wr_en_sfr = 1'b1; ram_wr_addr = 8'h98; ram_wr_byte = 8'hF0;
    @(negedge clk);
    ram_rd_en_sfr = 1'b0; ram_wr_en_sfr = 1'b0;
    vectors++; if (sfr_rd_byte !== 8'h10) begin miscompares++; $display("[TB] FAIL rd_wr_same got=%h exp=10", sfr_rd_byte); end
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'hF0) begin miscompares++; $display("[TB] FAIL scon_full_write got=%h exp=f0", d); end
    sfr_rd(8'h97, d, h);
    vectors++; if (h !== 1'b0) begin miscompares++; $display("[TB] FAIL unmapped_hit got=%b exp=0", h); end
    vectors++; if (d !== 8'hF0) begin miscompares++; $display("[TB] FAIL unmapped_hold got=%h exp=f0", d); end
    sfr_wr(8'h97, 8'hFF);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'hF0) begin miscompares++; $display("[TB] FAIL unmapped_write got=%h exp=f0", d); end
    sfr_rd(8'h99, d, h);
    vectors++; if (d !== 8'h00 || h !== 1'b1) begin miscompares++; $display("[TB] FAIL sbuf_reset got=%h/%b exp=00/1", d, h); end
  endtask

  task automatic test_tx;
    logic [7:0] d; logic h; logic [9:0] frame; logic ok;
    sfr_wr(8'h98, 8'h10);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h10) begin miscompares++; $display("[TB] FAIL tx_scon_setup got=%h exp=10", d); end
    frame = {1'b1, 8'h55, 1'b0};
    sfr_wr(8'h99, 8'h55);
    for (int i = 0; i < 160; i++) begin
      ram_wr_en_sfr = 1'b0; ram_rd_en_sfr = 1'b0;
      vectors++;
      if (uart_txd !== frame[i/16]) begin miscompares++; $display("[TB] FAIL tx_bit clk=%0d got=%b exp=%b", i, uart_txd, frame[i/16]); end
      if (i == 159) begin
        vectors++; if (sfr_rd_byte !== 8'h10) begin miscompares++; $display("[TB] FAIL ti_early got=%h exp=10", sfr_rd_byte); end
      end
      if (i == 40) begin ram_wr_en_sfr = 1'b1; ram_wr_addr = 8'h99; ram_wr_byte = 8'hFF; end
      if (i == 158) begin ram_rd_en_sfr = 1'b1; ram_rd_addr = 8'h98; end
      @(negedge clk);
    end
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h12) begin miscompares++; $display("[TB] FAIL ti_set got=%h exp=12", d); end
    ok = 1'b1;
    repeat (40) begin
      if (uart_txd !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_write_dropped got=%b exp=1", ok); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d; logic h; logic [9:0] frame;
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    sfr_wr(8'h98, 8'h10);
    sfr_wr(8'h99, bytes[0]);
    for (int f = 0; f < 2; f++) begin
      frame = {1'b1, bytes[f], 1'b0};
      for (int i = 0; i < 160; i++) begin
        ram_wr_en_sfr = 1'b0;
        vectors++;
        if (uart_txd !== frame[i/16]) begin miscompares++; $display("[TB] FAIL b2b f=%0d clk=%0d got=%b exp=%b", f, i, uart_txd, frame[i/16]); end
        if (f == 0 && i == 159) begin ram_wr_en_sfr = 1'b1; ram_wr_addr = 8'h99; ram_wr_byte = bytes[1]; end
        @(negedge clk);
      end
    end
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle got=%b exp=1", uart_txd); end
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h12) begin miscompares++; $display("[TB] FAIL b2b_ti got=%h exp=12", d); end
  endtask

  task automatic test_ti_collision;
    logic [7:0] d; logic h;
    sfr_wr(8'h98, 8'h10);
    sfr_wr(8'h99, 8'h81);
    for (int i = 0; i < 160; i++) begin
      ram_wr_en_sfr = 1'b0;
      if (i == 159) begin ram_wr_en_sfr = 1'b1; ram_wr_addr = 8'h98; ram_wr_byte = 8'h10; end
      @(negedge clk);
    end
    ram_wr_en_sfr = 1'b0;
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h12) begin miscompares++; $display("[TB] FAIL ti_collision got=%h exp=12", d); end
  endtask

  task automatic test_rx;
    logic [7:0] d; logic h;
    sfr_wr(8'h98, 8'h10);
    drive_rx_frame(8'hA3, 1'b1);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h11) begin miscompares++; $display("[TB] FAIL rx_ri got=%h exp=11", d); end
    sfr_rd(8'h99, d, h);
    vectors++; if (d !== 8'hA3) begin miscompares++; $display("[TB] FAIL rx_data got=%h exp=a3", d); end
    drive_rx_frame(8'h3C, 1'b1);
    sfr_rd(8'h99, d, h);
    vectors++; if (d !== 8'hA3) begin miscompares++; $display("[TB] FAIL rx_overrun got=%h exp=a3", d); end
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h11) begin miscompares++; $display("[TB] FAIL rx_overrun_scon got=%h exp=11", d); end
  endtask

  task automatic test_rx_errors;
    logic [7:0] d; logic h;
    sfr_wr(8'h98, 8'h10);
    drive_rx_frame(8'h5A, 1'b0);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h10) begin miscompares++; $display("[TB] FAIL framing_ri got=%h exp=10", d); end
    sfr_rd(8'h99, d, h);
    vectors++; if (d !== 8'hA3) begin miscompares++; $display("[TB] FAIL framing_data got=%h exp=a3", d); end
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h10) begin miscompares++; $display("[TB] FAIL glitch_ri got=%h exp=10", d); end
    drive_rx_frame(8'h96, 1'b1);
    sfr_rd(8'h99, d, h);
    vectors++; if (d !== 8'h96) begin miscompares++; $display("[TB] FAIL rx_after_glitch got=%h exp=96", d); end
    sfr_wr(8'h98, 8'h00);
    drive_rx_frame(8'h44, 1'b1);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL ren_off_ri got=%h exp=00", d); end
    sfr_rd(8'h99, d, h);
    vectors++; if (d !== 8'h96) begin miscompares++; $display("[TB] FAIL ren_off_data got=%h exp=96", d); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d; logic h; logic ok;
    sfr_wr(8'h98, 8'h10);
    sfr_wr(8'h99, 8'h00);
    repeat (88) @(negedge clk);
    vectors++; if (uart_txd !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_bit4 got=%b exp=0", uart_txd); end
    rst_n = 1'b0;
    #1;
    vectors++; if (uart_txd !== 1'b1) begin miscompares++; $display("[TB] FAIL async_reset_txd got=%b exp=1", uart_txd); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sfr_rd(8'h98, d, h);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("[TB] FAIL post_reset_scon got=%h exp=02", d); end
    ok = 1'b1;
    repeat (200) begin
      if (uart_txd !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL residual_frame got=%b exp=1", ok); end
  endtask

  initial begin
    rst_n = 1'b0;
    ram_rd_en_sfr = 1'b0; ram_rd_addr = 8'h00;
    ram_wr_en_sfr = 1'b0; ram_wr_addr = 8'h00; ram_wr_byte = 8'h00;
    uart_rxd = 1'b1;
    @(negedge clk);
    test_reset;
    test_addr_decode;
    test_tx;
    test_back_to_back;
    test_ti_collision;
    test_rx;
    test_rx_errors;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
